// File: rtl/frame_uart_streamer.sv
// Streams one frame-buffer frame onto a UART line as 8N1: a two-byte sync header,
// then every frame byte in address order, started by a rising edge of camera VS.
module frame_uart_streamer #(
  parameter int         CLKS_PER_BIT    = 1085,
  parameter int         BYTES_PER_FRAME = 9216,
  parameter int         ADDR_WIDTH      = 15,
  parameter logic [7:0] HDR0            = 8'hAA,
  parameter logic [7:0] HDR1            = 8'h55
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_VS,
  input  logic [7:0]            i_Rd_Data,
  output logic [ADDR_WIDTH-1:0] o_Rd_Addr,
  output logic                  o_Rd_En,
  output logic                  o_Tx,
  output logic                  o_Busy,
  output logic                  o_Frame_Done,
  output logic                  o_Frame_Indicator
);

  localparam logic [15:0]           CLK_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BYTE = ADDR_WIDTH'(BYTES_PER_FRAME - 1);
  localparam logic [3:0]            STOP_IDX  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state, state_next;
  logic                  vs_meta, vs_sync, vs_prev;
  logic                  trigger;
  logic [1:0]            hdr_cnt;
  logic [ADDR_WIDTH-1:0] byte_cnt;
  logic [7:0]            shift_reg;
  logic [15:0]           clk_cnt;
  logic [3:0]            bit_idx;
  logic                  frame_ind;
  logic                  is_header;
  logic                  bit_end;
  logic                  byte_end;

  assign trigger   = vs_sync & ~vs_prev;
  assign is_header = (hdr_cnt < 2'd2);
  assign bit_end   = (clk_cnt == CLK_LAST);
  assign byte_end  = bit_end && (bit_idx == STOP_IDX);

  // Synchroniser resets high so a VS already high at reset release is not
  // mistaken for a fresh rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= i_VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    o_Tx       = 1'b1;
    o_Rd_En    = 1'b0;
    o_Rd_Addr  = '0;
    case (state)
      S_IDLE: begin
        if (trigger) state_next = S_FETCH;
      end
      S_FETCH: begin
        o_Rd_En    = ~is_header;
        o_Rd_Addr  = byte_cnt;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        o_Rd_Addr  = byte_cnt;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (bit_idx == 4'd0) begin
          o_Tx = 1'b0;
        end else if (bit_idx != STOP_IDX) begin
          o_Tx = shift_reg[0];
        end
        if (byte_end) begin
          if (is_header || (byte_cnt != LAST_BYTE)) state_next = S_FETCH;
          else                                      state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hdr_cnt   <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      frame_ind <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            hdr_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        S_WAIT: begin
          case (hdr_cnt)
            2'd0:    shift_reg <= HDR0;
            2'd1:    shift_reg <= HDR1;
            default: shift_reg <= i_Rd_Data;
          endcase
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        S_SEND: begin
          if (!bit_end) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else begin
            clk_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
              bit_idx <= '0;
              if (is_header)                  hdr_cnt  <= hdr_cnt + 2'd1;
              else if (byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              // Data bits leave LSB first from bit 0 of the shifter.
              if (bit_idx != 4'd0) shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        S_DONE: begin
          frame_ind <= ~frame_ind;
        end
        default: ;
      endcase
    end
  end

  assign o_Busy            = (state != S_IDLE);
  assign o_Frame_Done      = (state == S_DONE);
  assign o_Frame_Indicator = frame_ind;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Directed bench for frame_uart_streamer: RAM model, passive UART/strobe monitor,
// one task per scenario with hand-computed expectations.
module tb_frame_uart_streamer;

  localparam int CPB      = 4;
  localparam int BPF      = 4;
  localparam int AW       = 15;
  localparam int BYTE_CYC = 10 * CPB + 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs    = 1'b0;
  logic [7:0]    rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_en, tx, busy, frame_done, frame_ind;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram       [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] exp_frame [6] = '{8'hAA, 8'h55, 8'h01, 8'h80, 8'hFF, 8'h00};

  always #5 clk = ~clk;

  frame_uart_streamer #(
    .CLKS_PER_BIT   (CPB),
    .BYTES_PER_FRAME(BPF),
    .ADDR_WIDTH     (AW),
    .HDR0           (8'hAA),
    .HDR1           (8'h55)
  ) dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_VS             (vs),
    .i_Rd_Data        (rd_data),
    .o_Rd_Addr        (rd_addr),
    .o_Rd_En          (rd_en),
    .o_Tx             (tx),
    .o_Busy           (busy),
    .o_Frame_Done     (frame_done),
    .o_Frame_Indicator(frame_ind)
  );

  // Synchronous RAM; junk on cycles not following a read strobe.
  always @(posedge clk) rd_data <= rd_en ? ram[rd_addr[1:0]] : 8'hC3;

  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         gap_q[$], start_q[$], fetch_q[$], done_q[$], addr_q[$];
  int         rd_cnt = 0, bit_err = 0;
  logic       samp[40];
  logic [7:0] rx_byte;
  bit         dec_active = 1'b0;
  int         dec_pos = 0, last_end = -1;
  logic       busy_d = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      dec_active = 1'b0;
      last_end   = -1;
      busy_d     = 1'b0;
    end else begin
      if (busy && !busy_d) fetch_q.push_back(cyc);
      if (!busy) last_end = -1;
      busy_d = busy;
      if (rd_en) begin
        rd_cnt++;
        addr_q.push_back(int'(rd_addr));
      end
      if (frame_done) done_q.push_back(cyc);
      if (!dec_active && tx === 1'b0) begin
        dec_active = 1'b1;
        dec_pos    = 0;
        start_q.push_back(cyc);
        if (last_end >= 0) gap_q.push_back(cyc - last_end - 1);
      end
      if (dec_active) begin
        samp[dec_pos] = tx;
        dec_pos++;
        if (dec_pos == 40) begin
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < CPB; j++)
              if (samp[k*CPB+j] !== samp[k*CPB]) bit_err++;
          if (samp[0] !== 1'b0)  bit_err++;
          if (samp[36] !== 1'b1) bit_err++;
          for (int k = 0; k < 8; k++) rx_byte[k] = samp[(k+1)*CPB];
          rx_q.push_back(rx_byte);
          dec_active = 1'b0;
          last_end   = cyc;
        end
      end
    end
  end

  task automatic clear_mon();
    rx_q.delete(); gap_q.delete(); start_q.delete();
    fetch_q.delete(); done_q.delete(); addr_q.delete();
    rd_cnt  = 0;
    bit_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vs    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_mon();
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (done_q.size() < target) begin
      n_bad++;
      $display("FAIL %s: timeout, frame_done count %0d, required %0d", name, done_q.size(), target);
    end
  endtask

  task automatic test_reset();
    int bad_tx = 0, bad_busy = 0, bad_rd = 0;
    do_reset();
    n_cmp++; if (tx !== 1'b1)       begin n_bad++; $display("FAIL reset_tx: got %b, required 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (rd_en !== 1'b0)    begin n_bad++; $display("FAIL reset_rd_en: got %b, required 0", rd_en); end
    n_cmp++; if (rd_addr !== '0)    begin n_bad++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, required 0", frame_done); end
    n_cmp++; if (frame_ind !== 1'b0)  begin n_bad++; $display("FAIL reset_ind: got %b, required 0", frame_ind); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1)    bad_tx++;
      if (busy !== 1'b0)  bad_busy++;
      if (rd_en !== 1'b0) bad_rd++;
    end
    n_cmp++; if (bad_tx != 0)   begin n_bad++; $display("FAIL idle_tx: %0d cycles not high, required 0", bad_tx); end
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL idle_busy: %0d cycles busy, required 0", bad_busy); end
    n_cmp++; if (bad_rd != 0)   begin n_bad++; $display("FAIL idle_rd_en: %0d strobes, required 0", bad_rd); end
  endtask

  task automatic test_single_frame();
    logic [7:0] got;
    int         a, f0, d0, s0;
    do_reset();
    vs = 1'b1;
    wait_done(1, 400, "single_done_wait");
    repeat (10) @(negedge clk);
    vs = 1'b0;
    n_cmp++; if (rx_q.size() != 6) begin n_bad++; $display("FAIL single_count: got %0d bytes, required 6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_cmp++;
      if (got !== exp_frame[i]) begin
        n_bad++;
        $display("FAIL single_byte%0d: got %h, required %h", i, got, exp_frame[i]);
      end
    end
    n_cmp++; if (rd_cnt != 4) begin n_bad++; $display("FAIL single_rd_strobes: got %0d, required 4", rd_cnt); end
    for (int i = 0; i < 4; i++) begin
      a = (i < addr_q.size()) ? addr_q[i] : -1;
      n_cmp++;
      if (a != i) begin n_bad++; $display("FAIL single_addr%0d: got %0d, required %0d", i, a, i); end
    end
    n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL single_done_count: got %0d, required 1", done_q.size()); end
    f0 = (fetch_q.size() > 0) ? fetch_q[0] : -1000;
    d0 = (done_q.size() > 0)  ? done_q[0]  : -1000;
    s0 = (start_q.size() > 0) ? start_q[0] : -1000;
    n_cmp++; if (d0 - f0 != 6 * BYTE_CYC) begin n_bad++; $display("FAIL single_frame_period: got %0d, required %0d", d0 - f0, 6 * BYTE_CYC); end
    n_cmp++; if (s0 - f0 != 2) begin n_bad++; $display("FAIL single_start_latency: got %0d, required 2", s0 - f0); end
    n_cmp++; if (frame_ind !== 1'b1) begin n_bad++; $display("FAIL single_indicator: got %b, required 1", frame_ind); end
  endtask

  task automatic test_bit_timing();
    int g, d;
    do_reset();
    vs = 1'b1;
    wait_done(1, 400, "timing_done_wait");
    repeat (5) @(negedge clk);
    vs = 1'b0;
    n_cmp++; if (bit_err != 0) begin n_bad++; $display("FAIL timing_bits: %0d bit errors, required 0", bit_err); end
    n_cmp++; if (gap_q.size() != 5) begin n_bad++; $display("FAIL timing_gap_count: got %0d, required 5", gap_q.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < gap_q.size()) ? gap_q[i] : -1;
      n_cmp++;
      if (g != 2) begin n_bad++; $display("FAIL timing_gap%0d: got %0d, required 2", i, g); end
    end
    for (int i = 1; i < 6; i++) begin
      d = (i < start_q.size()) ? start_q[i] - start_q[i-1] : -1;
      n_cmp++;
      if (d != BYTE_CYC) begin n_bad++; $display("FAIL timing_period%0d: got %0d, required %0d", i, d, BYTE_CYC); end
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] got;
    int         n = 0;
    do_reset();
    vs = 1'b1;
    while (rx_q.size() < 2 && n < 300) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (5) @(negedge clk);
    vs = 1'b1;
    wait_done(1, 400, "retrig_done_wait");
    repeat (100) @(negedge clk);
    n_cmp++; if (fetch_q.size() != 1) begin n_bad++; $display("FAIL retrig_ignored: got %0d frame starts, required 1", fetch_q.size()); end
    n_cmp++; if (rx_q.size() != 6) begin n_bad++; $display("FAIL retrig_bytes: got %0d, required 6", rx_q.size()); end
    n_cmp++; if (frame_ind !== 1'b1) begin n_bad++; $display("FAIL retrig_ind1: got %b, required 1", frame_ind); end
    vs = 1'b0;
    repeat (5) @(negedge clk);
    vs = 1'b1;
    wait_done(2, 400, "retrig_second_wait");
    repeat (5) @(negedge clk);
    vs = 1'b0;
    n_cmp++; if (rx_q.size() != 12) begin n_bad++; $display("FAIL retrig_second_count: got %0d, required 12", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (6 + i < rx_q.size()) ? rx_q[6+i] : 8'hxx;
      n_cmp++;
      if (got !== exp_frame[i]) begin n_bad++; $display("FAIL retrig_byte%0d: got %h, required %h", i, got, exp_frame[i]); end
    end
    n_cmp++; if (frame_ind !== 1'b0) begin n_bad++; $display("FAIL retrig_ind0: got %b, required 0", frame_ind); end
  endtask

  task automatic test_reset_mid_byte();
    int n = 0;
    do_reset();
    vs = 1'b1;
    while (!(rx_q.size() == 1 && dec_active && dec_pos == 18) && n < 300) begin @(negedge clk); n++; end
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_tx: got %b, required 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL midrst_tx: got %b, required 1", tx); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_cmp++; if (rd_en !== 1'b0)   begin n_bad++; $display("FAIL midrst_rd_en: got %b, required 0", rd_en); end
    n_cmp++; if (rd_addr !== '0)   begin n_bad++; $display("FAIL midrst_addr: got %0d, required 0", rd_addr); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b, required 0", frame_done); end
    n_cmp++; if (frame_ind !== 1'b0)  begin n_bad++; $display("FAIL midrst_ind: got %b, required 0", frame_ind); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (200) @(negedge clk);
    n_cmp++; if (fetch_q.size() != 0 || start_q.size() != 0) begin
      n_bad++; $display("FAIL midrst_no_resume: got %0d starts, required 0", fetch_q.size() + start_q.size());
    end
    vs = 1'b0;
    repeat (5) @(negedge clk);
    vs = 1'b1;
    wait_done(1, 400, "midrst_new_frame");
    n_cmp++; if (rx_q.size() != 6) begin n_bad++; $display("FAIL midrst_new_bytes: got %0d, required 6", rx_q.size()); end
    vs = 1'b0;
  endtask

  task automatic test_glitch();
    int n0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 vs = 1'b1;
      #2 vs = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    n_cmp++; if (fetch_q.size() > 1) begin n_bad++; $display("FAIL glitch_starts: got %0d, required at most 1", fetch_q.size()); end
    n_cmp++; if (rx_q.size() != 6 * done_q.size()) begin
      n_bad++; $display("FAIL glitch_bytes: got %0d bytes for %0d frames", rx_q.size(), done_q.size());
    end
    n0 = done_q.size();
    @(negedge clk);
    vs = 1'b1;
    wait_done(n0 + 1, 400, "steady_first_wait");
    repeat (600) @(negedge clk);
    n_cmp++; if (done_q.size() != n0 + 1) begin n_bad++; $display("FAIL steady_no_retrig: got %0d frames, required %0d", done_q.size(), n0 + 1); end
    vs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bit_timing();
    test_retrigger();
    test_reset_mid_byte();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
